// File: rtl/elpis_host_pkg.sv
// elpis_host_pkg: register offsets, STAT bit positions, FSM states and byte-merge helper for wb_host_bridge.
package elpis_host_pkg;
  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_ADDR  = 8'h01;
  localparam logic [7:0] OFF_DATA  = 8'h02;
  localparam logic [7:0] OFF_STAT  = 8'h03;
  localparam logic [7:0] OFF_PRINT = 8'h04;
  localparam logic [7:0] OFF_INPUT = 8'h05;
  localparam int STAT_PV   = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_IN   = 2;
  localparam int STAT_BUSY = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT} state_e;
  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] sel);
    return {sel[3] ? n[31:24] : o[31:24], sel[2] ? n[23:16] : o[23:16],
            sel[1] ? n[15:8] : o[15:8], sel[0] ? n[7:0] : o[7:0]};
  endfunction
endpackage

// File: rtl/host_print_latch.sv
// host_print_latch: captures print words, tracks valid/overflow, cleared by a PRINT read.
module host_print_latch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        clr_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        ovf_o
);
  logic [31:0] data_q;
  logic        valid_q, ovf_q;
  // A word arriving with the clearing read survives it; overflow only counts uncleared words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (valid_i) data_q <= data_i;
      valid_q <= valid_i | (valid_q & ~clr_i);
      ovf_q   <= ~clr_i & (ovf_q | (valid_i & valid_q));
    end
  end
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/wb_host_bridge.sv
// wb_host_bridge: Wishbone classic slave giving firmware control of core load, reset, print and input paths.
module wb_host_bridge
  import elpis_host_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              load_mode_o,
  output logic              core_reset_o,
  output logic [ADDR_W-1:0] load_addr_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  input  logic              load_ready_i,
  input  logic [31:0]       print_data_i,
  input  logic              print_valid_i,
  output logic [31:0]       in_data_o,
  output logic              in_valid_o,
  input  logic              in_ready_i
);
  state_e              state_q;
  logic                ack_q, load_valid_q, in_valid_q;
  logic [1:0]          ctrl_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         dat_q, load_data_q, in_data_q, rdata, p_data;
  logic [3:0]          stat;
  logic [7:0]          off;
  logic                req, full, p_valid, p_ovf, p_clr;
  assign off  = wbs_adr_i[7:0] >> 2;
  assign req  = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign full = wbs_sel_i == 4'hF;
  assign p_clr = (state_q == ST_IDLE) & req & ~wbs_we_i & (off == OFF_PRINT);
  host_print_latch u_print (
    .clk(clk), .rst_n(rst_n), .data_i(print_data_i), .valid_i(print_valid_i),
    .clr_i(p_clr), .data_o(p_data), .valid_o(p_valid), .ovf_o(p_ovf)
  );
  always_comb begin
    stat = '0;
    stat[STAT_PV]   = p_valid;
    stat[STAT_OVF]  = p_ovf;
    stat[STAT_IN]   = in_valid_q;
    stat[STAT_BUSY] = load_valid_q;
    rdata = off == OFF_CTRL  ? {30'd0, ctrl_q} :
            off == OFF_ADDR  ? 32'(addr_q) :
            off == OFF_STAT  ? {28'd0, stat} :
            off == OFF_PRINT ? p_data : '0;
  end
  // Ack is raised on leaving ACK, so it is seen the cycle after; the ~ack_q term in req blocks a re-trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      ctrl_q       <= 2'b10;
      addr_q       <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      in_data_q    <= '0;
      in_valid_q   <= 1'b0;
    end else begin
      if (in_ready_i) in_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          dat_q <= '0;
          if (req) begin
            state_q <= ST_ACK;
            if (!wbs_we_i) dat_q <= rdata;
            else begin
              if (off == OFF_CTRL && wbs_sel_i[0]) ctrl_q <= wbs_dat_i[1:0];
              if (off == OFF_ADDR) addr_q <= ADDR_W'(byte_merge(32'(addr_q), wbs_dat_i, wbs_sel_i));
              if (off == OFF_INPUT && full) begin
                in_data_q  <= wbs_dat_i;
                in_valid_q <= 1'b1;
              end
              if (off == OFF_DATA && full) begin
                load_data_q  <= wbs_dat_i;
                load_valid_q <= 1'b1;
                state_q      <= ST_WAIT;
              end
            end
          end
        end
        ST_ACK: begin
          ack_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_WAIT: if (load_ready_i) begin
          load_valid_q <= 1'b0;
          addr_q       <= addr_q + ADDR_W'(1);
          state_q      <= wbs_cyc_i ? ST_ACK : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign load_mode_o  = ctrl_q[0];
  assign core_reset_o = ctrl_q[1];
  assign load_addr_o  = addr_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;
  assign in_data_o    = in_data_q;
  assign in_valid_o   = in_valid_q;
endmodule

// File: tb/tb_wb_host_bridge.sv
// tb_wb_host_bridge: directed Wishbone accesses against wb_host_bridge with hand-computed expectations.
module tb_wb_host_bridge;
  localparam logic [31:0] B = 32'h3000_0000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        load_mode, core_reset, load_valid, load_ready = 1'b0;
  logic [19:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] print_data = '0;
  logic        print_valid = 1'b0;
  logic [31:0] in_data;
  logic        in_valid, in_ready = 1'b0;
  int          passed = 0, total = 0;
  logic [31:0] rd;
  int          lat;
  wb_host_bridge dut (
    .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .load_mode_o(load_mode), .core_reset_o(core_reset), .load_addr_o(load_addr),
    .load_data_o(load_data), .load_valid_o(load_valid), .load_ready_i(load_ready),
    .print_data_i(print_data), .print_valid_i(print_valid), .in_data_o(in_data),
    .in_valid_o(in_valid), .in_ready_i(in_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask
  task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r, output int l);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    l = -1; r = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack) begin
        l = i;
        r = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_core_reset", 32'(core_reset), 1);
    check("rst_load_mode", 32'(load_mode), 0);
    check("rst_load_valid", 32'(load_valid), 0);
    check("rst_ack", 32'(ack), 0);
    rst_n = 1'b1;
    wb_acc(0, B + 32'h00, 0, 4'hF, rd, lat);
    check("ctrl_rst_read", rd, 32'h2);
    check("reg_latency", lat, 2);
    wb_acc(1, B + 32'h00, 32'h1, 4'hF, rd, lat);
    check("ctrl_load_mode", 32'(load_mode), 1);
    check("ctrl_core_reset", 32'(core_reset), 0);
    // Load with ready three cycles after the request appears
    wb_acc(1, B + 32'h04, 32'h10, 4'hF, rd, lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = B + 32'h08; wdat = 32'hDEAD_BEEF; sel = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("load_valid_held", 32'(load_valid), 1);
      check("load_addr_held", 32'(load_addr), 32'h10);
      check("load_data_held", load_data, 32'hDEAD_BEEF);
      check("load_no_early_ack", 32'(ack), 0);
    end
    load_ready = 1'b1;
    @(negedge clk);
    load_ready = 1'b0;
    check("load_valid_dropped", 32'(load_valid), 0);
    check("load_ack_not_yet", 32'(ack), 0);
    @(negedge clk);
    check("load_ack", 32'(ack), 1);
    check("load_ack_dat", rdat, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_acc(0, B + 32'h04, 0, 4'hF, rd, lat);
    check("addr_incr", rd, 32'h11);
    wb_acc(1, B + 32'h04, 32'hAABB_CCDD, 4'h1, rd, lat);
    wb_acc(0, B + 32'h04, 0, 4'hF, rd, lat);
    check("addr_sel1", rd, 32'h000DD);
    wb_acc(1, B + 32'h04, 32'hAABB_CCDD, 4'h6, rd, lat);
    wb_acc(0, B + 32'h04, 0, 4'hF, rd, lat);
    check("addr_sel6", rd, 32'hBCCDD);
    // Wrap with ready already high
    wb_acc(1, B + 32'h04, 32'hFFFFF, 4'hF, rd, lat);
    load_ready = 1'b1;
    wb_acc(1, B + 32'h08, 32'h1234_5678, 4'hF, rd, lat);
    load_ready = 1'b0;
    check("wrap_latency", lat, 3);
    wb_acc(0, B + 32'h04, 0, 4'hF, rd, lat);
    check("addr_wrap", rd, 32'h0);
    // Print latch
    @(negedge clk);
    print_valid = 1'b1; print_data = 32'h11;
    @(negedge clk);
    print_data = 32'h22;
    @(negedge clk);
    print_valid = 1'b0;
    wb_acc(0, B + 32'h0C, 0, 4'hF, rd, lat);
    check("stat_print_ovf", rd, 32'h3);
    wb_acc(0, B + 32'h10, 0, 4'hF, rd, lat);
    check("print_read", rd, 32'h22);
    wb_acc(0, B + 32'h0C, 0, 4'hF, rd, lat);
    check("stat_cleared", rd, 32'h0);
    @(negedge clk);
    print_valid = 1'b1; print_data = 32'h33;
    @(negedge clk);
    print_valid = 1'b0;
    fork
      wb_acc(0, B + 32'h10, 0, 4'hF, rd, lat);
      begin
        @(negedge clk);
        print_valid = 1'b1; print_data = 32'h44;
        @(negedge clk);
        print_valid = 1'b0;
      end
    join
    check("print_race_old", rd, 32'h33);
    wb_acc(0, B + 32'h0C, 0, 4'hF, rd, lat);
    check("print_race_stat", rd, 32'h1);
    wb_acc(0, B + 32'h10, 0, 4'hF, rd, lat);
    check("print_race_new", rd, 32'h44);
    // Interactive input
    wb_acc(1, B + 32'h14, 32'h5, 4'hF, rd, lat);
    check("in_valid_set", 32'(in_valid), 1);
    check("in_data", in_data, 32'h5);
    wb_acc(0, B + 32'h0C, 0, 4'hF, rd, lat);
    check("stat_in_pending", rd, 32'h4);
    @(negedge clk);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    check("in_valid_cleared", 32'(in_valid), 0);
    wb_acc(0, B + 32'h0C, 0, 4'hF, rd, lat);
    check("stat_in_clear", rd, 32'h0);
    wb_acc(1, B + 32'h14, 32'h7, 4'hF, rd, lat);
    fork
      wb_acc(1, B + 32'h14, 32'h9, 4'hF, rd, lat);
      begin
        @(negedge clk);
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
      end
    join
    check("in_race_valid", 32'(in_valid), 1);
    check("in_race_data", in_data, 32'h9);
    wb_acc(1, B + 32'h14, 32'hAB, 4'h3, rd, lat);
    check("in_partial_ignored", in_data, 32'h9);
    // Edge cases
    wb_acc(1, B + 32'h08, 32'hCAFE, 4'h3, rd, lat);
    check("data_partial_lat", lat, 2);
    check("data_partial_noload", 32'(load_valid), 0);
    wb_acc(0, B + 32'h20, 0, 4'hF, rd, lat);
    check("unmapped_read", rd, 0);
    check("unmapped_lat", lat, 2);
    wb_acc(0, B + 32'h08, 0, 4'hF, rd, lat);
    check("wo_read", rd, 0);
    wb_acc(1, 32'h4000_0000, 32'h3, 4'hF, rd, lat);
    check("out_of_window_noack", lat, -1);
    check("out_of_window_ctrl", 32'(core_reset), 0);
    // Cycle abandoned during load
    wb_acc(1, B + 32'h04, 32'h5, 4'hF, rd, lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = B + 32'h08; wdat = 32'h55; sel = 4'hF;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    load_ready = 1'b1;
    @(negedge clk);
    load_ready = 1'b0;
    check("drop_load_done", 32'(load_valid), 0);
    @(negedge clk);
    check("drop_no_ack", 32'(ack), 0);
    wb_acc(0, B + 32'h04, 0, 4'hF, rd, lat);
    check("drop_addr_incr", rd, 32'h6);
    // Reset during WAIT_LOAD
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = B + 32'h08; wdat = 32'h77; sel = 4'hF;
    @(negedge clk);
    check("pre_reset_valid", 32'(load_valid), 1);
    rst_n = 1'b0;
    #1;
    check("reset_kills_load", 32'(load_valid), 0);
    check("reset_core_reset", 32'(core_reset), 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_acc(0, B + 32'h04, 0, 4'hF, rd, lat);
    check("reset_addr", rd, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
